// File: rtl/mul_or_arbiter.sv
// mul_or_arbiter: two requesters share one ((a*b) | c) datapath.
// A round-robin arbiter grants at most one requester per cycle into a
// single result register. Per-requester counters track accepted operations.
//
// Handshake: a transfer happens on any channel when valid && ready are both
// high in the same cycle. Valid never waits for ready. Ready is only offered
// when the result register is free or being drained in this cycle, and never
// while rst is high.
module mul_or_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic [15:0]      issue_cnt0,
  output logic [15:0]      issue_cnt1
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_id;
  logic             r_prio;
  logic [15:0]      r_cnt0;
  logic [15:0]      r_cnt1;

  logic             w_can_issue;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_grant;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_sel_c;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_result;

  // The slot is free when it is empty or when the consumer drains it this cycle.
  assign w_can_issue = !r_out_valid || out_ready;
  assign w_out_xfer  = r_out_valid && out_ready;

  // Arbitration. A lone requester wins. On contention, r_prio picks the winner.
  // The other requester's valid only matters when contention is resolved.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst && w_can_issue) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = !r_prio;
        w_grant1 = r_prio;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign w_grant    = w_grant0 || w_grant1;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Operand select for the shared datapath. Requester 1 is chosen only when it holds the grant.
  always_comb begin
    w_sel_a = req0_a;
    w_sel_b = req0_b;
    w_sel_c = req0_c;
    if (w_grant1) begin
      w_sel_a = req1_a;
      w_sel_b = req1_b;
      w_sel_c = req1_c;
    end
  end

  // The product is truncated to WIDTH bits by the result width, then ORed with c.
  assign w_prod   = w_sel_a * w_sel_b;
  assign w_result = w_prod | w_sel_c;

  // Result register. It loads only on a grant, so later operand changes and backpressure leave it stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 1'b0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_id    <= w_grant1;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer. After a grant it points at the loser. With no grant it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_grant) begin
      r_prio <= w_grant0;
    end
  end

  // Per-requester accepted-operation counters. They wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant0) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_grant1) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_id     = r_out_id;
  assign issue_cnt0 = r_cnt0;
  assign issue_cnt1 = r_cnt1;

endmodule

// File: tb/tb_mul_or_arbiter.sv
// Testbench for mul_or_arbiter: directed vector table, hand sequences for
// backpressure / mid-flight reset / counter wrap, then random traffic
// checked against a behavioural model with an expected-result queue.
module tb_mul_or_arbiter;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req1_valid, out_ready;
  logic [W-1:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
  logic         req0_ready, req1_ready, out_valid, out_id;
  logic [W-1:0] out_data;
  logic [15:0]  issue_cnt0, issue_cnt1;

  mul_or_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         m_valid;
  logic         m_prio;
  logic [15:0]  m_cnt0, m_cnt1;
  logic [W:0]   exp_q[$];   // {id, data} of results expected on the output
  logic         s_ready0, s_ready1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_prio  = 1'b0;
    m_cnt0  = 16'd0;
    m_cnt1  = 16'd0;
    exp_q.delete();
  endtask

  // Reference result: full 32-bit product, keep the low W bits, OR with c.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    int unsigned p;
    p = int'(a) * int'(b);
    return (p % 65536) | c;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] c0, input logic v1, input logic [W-1:0] a1,
                       input logic [W-1:0] b1, input logic [W-1:0] c1, input logic ordy);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_c = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_c = c1;
    out_ready  = ordy;
  endtask

  // One clock cycle. Called 1 time unit after a rising edge, with inputs already driven.
  // Samples combinational readies at the falling edge. Checks registered state after the next rising edge.
  task automatic cycle();
    logic         free, g0, g1;
    logic [W-1:0] res;
    #4;
    s_ready0 = req0_ready;
    s_ready1 = req1_ready;
    free = !m_valid || out_ready;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && free) begin
      if (req0_valid && req1_valid) begin
        if (m_prio) g1 = 1'b1; else g0 = 1'b1;
      end else if (req0_valid) g0 = 1'b1;
      else if (req1_valid) g1 = 1'b1;
    end
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    if (!rst && m_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL out_xfer: output transfer with empty expected queue at %0t", $time);
      end else begin
        chk("out_result", {15'd0, out_id, out_data}, {15'd0, exp_q.pop_front()});
      end
    end
    res = g1 ? ref_op(req1_a, req1_b, req1_c) : ref_op(req0_a, req0_b, req0_c);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (g0 || g1) begin
        m_valid = 1'b1;
        exp_q.push_back({g1, res});
        m_prio = g0;
        if (g0) m_cnt0 = m_cnt0 + 16'd1;
        if (g1) m_cnt1 = m_cnt1 + 16'd1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("issue_cnt0", {16'd0, issue_cnt0}, {16'd0, m_cnt0});
    chk("issue_cnt1", {16'd0, issue_cnt1}, {16'd0, m_cnt1});
    if (m_valid && exp_q.size() > 0)
      chk("held_result", {15'd0, out_id, out_data}, {15'd0, exp_q[0]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         v0;
    logic [W-1:0] a0, b0, c0;
    logic         v1;
    logic [W-1:0] a1, b1, c1;
    logic         ordy;
    logic         er0, er1, ev;
    logic [W-1:0] ed;
    logic         eid;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 16'd3, 16'd5, 16'h0010, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1,
               1'b1, 1'b0, 1'b1, 16'h001F, 1'b0};
    tbl[1] = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 16'h0100, 16'h0100, 16'h0001, 1'b1,
               1'b0, 1'b1, 1'b1, 16'h0001, 1'b1};
    tbl[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16'd9, 16'd9, 16'd9, 1'b1,
               1'b1, 1'b0, 1'b1, 16'h0001, 1'b0};
    tbl[3] = '{1'b1, 16'd9, 16'd9, 16'd9, 1'b1, 16'h1234, 16'h0002, 16'h8000, 1'b1,
               1'b0, 1'b1, 1'b1, 16'hA468, 1'b1};
    tbl[4] = '{1'b0, 16'd1, 16'd1, 16'd1, 1'b0, 16'd1, 16'd1, 16'd1, 1'b1,
               1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[5] = '{1'b1, 16'd7, 16'd9, 16'h0100, 1'b1, 16'd2, 16'd2, 16'd0, 1'b1,
               1'b1, 1'b0, 1'b1, 16'h013F, 1'b0};
    tbl[6] = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 16'h00FF, 16'h0101, 16'h0000, 1'b1,
               1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1};

    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_out_data", {16'd0, out_data}, 32'd0);
    chk("reset_out_id", {31'd0, out_id}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);

    // Table: from reset, full-rate output. Covers the single-issue case, truncation, and alternation under contention.
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].c0,
            tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].ordy);
      cycle();
      chk($sformatf("tbl%0d_ready0", i), {31'd0, s_ready0}, {31'd0, tbl[i].er0});
      chk($sformatf("tbl%0d_ready1", i), {31'd0, s_ready1}, {31'd0, tbl[i].er1});
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), {16'd0, out_data}, {16'd0, tbl[i].ed});
        chk($sformatf("tbl%0d_id", i), {31'd0, out_id}, {31'd0, tbl[i].eid});
      end
    end
    chk("tbl_cnt0", {16'd0, issue_cnt0}, 32'd3);
    chk("tbl_cnt1", {16'd0, issue_cnt1}, 32'd3);

    // Backpressure: hold for 3 cycles with both requesters asking, then drain and grant in the same cycle.
    do_reset();
    drive(1'b1, 16'd3, 16'd5, 16'h0010, 1'b1, 16'd2, 16'd3, 16'd0, 1'b1);
    cycle();
    chk("bp_first_grant0", {31'd0, s_ready0}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), W'($urandom),
            1'b1, W'($urandom), W'($urandom), W'($urandom), 1'b0);
      cycle();
      chk("bp_ready0", {31'd0, s_ready0}, 32'd0);
      chk("bp_ready1", {31'd0, s_ready1}, 32'd0);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", {16'd0, out_data}, 32'h001F);
      chk("bp_hold_id", {31'd0, out_id}, 32'd0);
    end
    drive(1'b1, 16'd1, 16'd1, 16'd1, 1'b1, 16'd2, 16'd3, 16'd0, 1'b1);
    cycle();
    chk("bp_release_grant1", {31'd0, s_ready1}, 32'd1);
    chk("bp_release_data", {16'd0, out_data}, 32'h0006);
    chk("bp_release_id", {31'd0, out_id}, 32'd1);

    // Mid-flight reset: a held result is discarded, and requester 0 wins the first grant afterwards.
    do_reset();
    drive(1'b1, 16'd1, 16'd1, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
    cycle();
    drive(1'b1, 16'd1, 16'd1, 16'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    cycle();
    chk("mr_held_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 16'd5, 16'd5, 16'd0, 1'b1, 16'd6, 16'd6, 16'd0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mr_rst_ready0", {31'd0, s_ready0}, 32'd0);
    chk("mr_rst_ready1", {31'd0, s_ready1}, 32'd0);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_cnt0", {16'd0, issue_cnt0}, 32'd0);
    chk("mr_cnt1", {16'd0, issue_cnt1}, 32'd0);
    drive(1'b1, 16'd4, 16'd4, 16'd1, 1'b1, 16'd6, 16'd6, 16'd0, 1'b1);
    cycle();
    chk("mr_first_grant0", {31'd0, s_ready0}, 32'd1);
    chk("mr_first_grant1", {31'd0, s_ready1}, 32'd0);
    chk("mr_data", {16'd0, out_data}, 32'h0011);
    chk("mr_id", {31'd0, out_id}, 32'd0);

    // Counter wrap: 65536 requester-0 transfers bring issue_cnt0 back to zero.
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, W'(i), W'(i + 1), W'(i >> 3), 1'b0, '0, '0, '0, 1'b1);
      cycle();
      if (i == 65534) chk("wrap_cnt0_ffff", {16'd0, issue_cnt0}, 32'h0000FFFF);
    end
    chk("wrap_cnt0_zero", {16'd0, issue_cnt0}, 32'd0);
    chk("wrap_cnt1_zero", {16'd0, issue_cnt1}, 32'd0);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), W'($urandom),
            1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), W'($urandom),
            1'($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_or_arbiter.md
MUL_OR_ARBITER -- requirements
Module: mul_or_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req0_valid  input  1  requester 0 offers an operation.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b, req0_c  input  WIDTH each  requester 0 operands.
REQ-007 Port: req1_valid, req1_ready, req1_a, req1_b, req1_c  same widths and meanings as requester 0, for requester 1.
REQ-008 Port: out_valid  output  1  result register holds a result.
REQ-009 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-010 Port: out_data  output  WIDTH  result ((a*b) | c), low WIDTH bits.
REQ-011 Port: out_id  output  1  requester that issued the result (0 or 1).
REQ-012 Port: issue_cnt0, issue_cnt1  output  16 each  count of operations accepted per requester.

Function
REQ-013 The block SHALL contain exactly one shared datapath computing ((a*b) | c): WIDTH x WIDTH multiply truncated to WIDTH bits, then bitwise OR with c, then one result register (out_data).
REQ-014 Transfer on a requester: reqN_valid && reqN_ready in the same cycle; transfer on the output: out_valid && out_ready.
REQ-015 Pipeline free (can_issue) SHALL be: !out_valid || out_ready, evaluated combinationally in the current cycle.
REQ-016 Grant: at most one reqN_ready high per cycle; reqN_ready SHALL be 0 whenever can_issue is 0.
REQ-017 Only requester N valid and can_issue: grant N.
REQ-018 Both valid and can_issue: grant the requester selected by the round-robin pointer prio (0 = requester 0 first).
REQ-019 prio SHALL update only on a grant, to the index of the requester that was not granted; no grant leaves prio unchanged.
REQ-020 reqN_ready SHALL NOT depend combinationally on reqN_valid of the other requester except through the arbitration of REQ-017/018.
REQ-021 Latency: an operation accepted in cycle t SHALL present out_valid=1, out_data and out_id in cycle t+1.
REQ-022 out_valid next state: 1 if a grant occurs; else 0 if the output transfers; else unchanged.
REQ-023 Backpressure: while out_valid=1 and out_ready=0, out_data, out_id, out_valid SHALL hold stable and no grant occurs.
REQ-024 Simultaneous output transfer and new grant in the same cycle SHALL be allowed (full throughput, one op per cycle).
REQ-025 issue_cntN SHALL increment by 1 on each requester-N transfer, wrapping 0xFFFF -> 0x0000.
REQ-026 Requester operands SHALL be sampled only in the grant cycle; later operand changes do not affect a registered result.

Reset
REQ-027 With rst=1 at a rising edge: out_valid=0, out_data=0, out_id=0, prio=0, issue_cnt0=0, issue_cnt1=0.
REQ-028 During a cycle with rst=1, req0_ready and req1_ready SHALL be 0; operations offered that cycle are not accepted and not counted.
REQ-029 Reset mid-operation SHALL discard any held result; the first grant after reset SHALL favour requester 0 if both are valid.

Verification
REQ-030 Single issue: rst released, req0 valid a=3,b=5,c=0x10, out_ready=1 -> req0_ready=1 that cycle; next cycle out_valid=1, out_data=0x001F, out_id=0; issue_cnt0=1.
REQ-031 Truncation: req1 a=0x0100,b=0x0100,c=0x0001 -> out_data=0x0001, out_id=1.
REQ-032 Contention: both valid continuously, out_ready=1 -> grants alternate 0,1,0,1 from reset; out_id sequence matches; one result per cycle.
REQ-033 Backpressure: result pending, out_ready=0 for 3 cycles with both requesters valid -> both ready=0, out_data/out_id stable for 3 cycles; out_ready=1 -> result consumed and next grant in the same cycle.
REQ-034 Wrap: force 65536 requester-0 transfers -> issue_cnt0 returns to 0x0000; issue_cnt1 unchanged.
REQ-035 Reset mid-flight: out_valid=1 held by out_ready=0, assert rst one cycle -> out_valid=0, counters 0, prio=0; subsequent both-valid grant goes to requester 0.
